// File: rtl/port_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | port_pkg: 8051 port SFR addresses, bit bases and reset constants  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package port_pkg;
  localparam logic [7:0] P0_ADDR          = 8'h80;
  localparam logic [7:0] P1_ADDR          = 8'h90;
  localparam logic [7:0] P2_ADDR          = 8'hA0;
  localparam logic [7:0] P3_ADDR          = 8'hB0;
  localparam logic [7:0] P0_BIT_BASE      = 8'h80;
  localparam logic [7:0] P1_BIT_BASE      = 8'h90;
  localparam logic [7:0] P2_BIT_BASE      = 8'hA0;
  localparam logic [7:0] P3_BIT_BASE      = 8'hB0;
  localparam logic [7:0] BIT_BASE_MASK    = 8'hF8;
  localparam logic [7:0] PORT_RST         = 8'hFF;
  localparam int         DEGLITCH_DEFAULT = 4;
endpackage
`default_nettype wire

// File: rtl/port_reader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | port_reader_if: SFR read request/response bundle for one port     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface port_reader_if;
  logic [7:0] addr;
  logic       read_en;
  logic       read_bit_en;
  logic       rmw;
  logic [7:0] data_out;
  logic       bit_out;
  logic       read_valid;

  modport master (
    output addr, read_en, read_bit_en, rmw,
    input  data_out, bit_out, read_valid
  );

  modport slave (
    input  addr, read_en, read_bit_en, rmw,
    output data_out, bit_out, read_valid
  );
endinterface
`default_nettype wire

// File: rtl/port_sync_bit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | port_sync_bit: one pin's 2-flop synchronizer, optional deglitch   |
// | filter (PORT_DEGLITCH_EN) and edge detect.   Revision: 1.0        |
// +------------------------------------------------------------------+
module port_sync_bit #(
  parameter int   DEGLITCH_CYC = 4,
  parameter logic RST_LEVEL    = 1'b1
) (
  input  wire  clock,
  input  wire  reset,
  input  wire  pin_in,
  output logic level,
  output logic pin_edge
);
  if (DEGLITCH_CYC < 2 || DEGLITCH_CYC > 15) begin : g_bad_cfg
    $error("port_sync_bit: DEGLITCH_CYC must be within 2..15");
  end

  logic s1_q, s1_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

`ifdef PORT_DEGLITCH_EN
  // Counter hits CNT_LAST on the DEGLITCH_CYC-th consecutive differing cycle.
  localparam logic [3:0] CNT_LAST = 4'(DEGLITCH_CYC - 1);

  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q <= RST_LEVEL;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q;
`endif

  always_comb begin
    s1_d   = pin_in;
    sync_d = s1_q;
    prev_d = level;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= RST_LEVEL;
      sync_q <= RST_LEVEL;
      prev_q <= RST_LEVEL;
    end else begin
      s1_q   <= s1_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pin_edge = level ^ prev_q;
endmodule
`default_nettype wire

// File: rtl/port_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | port_reader: 8051 port SFR read side with sticky change flags;    |
// | PORT_DEGLITCH_EN adds per-pin filtering.     Revision: 1.0        |
// +------------------------------------------------------------------+
module port_reader
  import port_pkg::*;
#(
  parameter logic [7:0] SFR_ADDR     = P0_ADDR,
  parameter logic [7:0] SFR_B_ADDR   = P0_BIT_BASE,
  parameter int         DEGLITCH_CYC = DEGLITCH_DEFAULT
) (
  input  wire         clock,
  input  wire         reset,
  input  wire  [7:0]  pins_in,
  input  wire  [7:0]  latch_in,
  port_reader_if.slave sfr,
  output logic [7:0]  pin_change
);
  logic [7:0] pin_sync;
  logic [7:0] pin_edge;

  for (genvar i = 0; i < 8; i++) begin : g_pin
    port_sync_bit #(
      .DEGLITCH_CYC (DEGLITCH_CYC),
      .RST_LEVEL    (PORT_RST[i])
    ) u_sync (
      .clock    (clock),
      .reset    (reset),
      .pin_in   (pins_in[i]),
      .level    (pin_sync[i]),
      .pin_edge (pin_edge[i])
    );
  end

  logic [7:0] data_out_q, data_out_d;
  logic       bit_out_q, bit_out_d;
  logic       read_valid_q, read_valid_d;
  logic [7:0] pin_change_q, pin_change_d;
  logic       byte_hit, bit_hit;
  logic [7:0] src;

  always_comb begin
    byte_hit     = sfr.read_en & ~sfr.read_bit_en & (sfr.addr == SFR_ADDR);
    bit_hit      = sfr.read_en & sfr.read_bit_en &
                   ((sfr.addr & BIT_BASE_MASK) == (SFR_B_ADDR & BIT_BASE_MASK));
    src          = sfr.rmw ? latch_in : pin_sync;
    data_out_d   = data_out_q;
    bit_out_d    = bit_out_q;
    read_valid_d = byte_hit | bit_hit;
    if (byte_hit) data_out_d = src;
    if (bit_hit)  bit_out_d  = src[sfr.addr[2:0]];
    // OR-ing new edges after the clear lets a same-cycle edge survive a poll.
    pin_change_d = ((byte_hit & ~sfr.rmw) ? 8'h00 : pin_change_q) | pin_edge;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q   <= 8'h00;
      bit_out_q    <= 1'b0;
      read_valid_q <= 1'b0;
      pin_change_q <= 8'h00;
    end else begin
      data_out_q   <= data_out_d;
      bit_out_q    <= bit_out_d;
      read_valid_q <= read_valid_d;
      pin_change_q <= pin_change_d;
    end
  end

  assign sfr.data_out   = data_out_q;
  assign sfr.bit_out    = bit_out_q;
  assign sfr.read_valid = read_valid_q;
  assign pin_change     = pin_change_q;
endmodule
`default_nettype wire

// File: tb/tb_port_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_port_reader: scoreboard bench for the port_reader SFR block    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_port_reader;
`ifdef PORT_DEGLITCH_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  localparam int SETTLE = LAT + 4;

  typedef struct packed {
    logic       is_bit;
    logic [7:0] val;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pins_in = 8'hFF;
  logic [7:0] latch_in = 8'h00;
  logic [7:0] pin_change;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  port_reader_if sfr ();

  port_reader dut (
    .clock      (clock),
    .reset      (reset),
    .pins_in    (pins_in),
    .latch_in   (latch_in),
    .sfr        (sfr),
    .pin_change (pin_change)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one access for a cycle; hits push their expected result.
  task automatic issue_read(input logic [7:0] a, input logic is_bit, input logic r,
                            input logic hit, input logic [7:0] exp_val);
    exp_t e;
    sfr.addr        = a;
    sfr.read_bit_en = is_bit;
    sfr.rmw         = r;
    sfr.read_en     = 1'b1;
    if (hit) begin
      e.is_bit = is_bit;
      e.val    = exp_val;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic idle();
    sfr.read_en     = 1'b0;
    sfr.read_bit_en = 1'b0;
    sfr.rmw         = 1'b0;
    sfr.addr        = 8'h00;
  endtask

  always @(posedge clock) begin
    #1;
    if (sfr.read_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(sfr.read_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_bit) check("bit_out", 32'(sfr.bit_out), 32'(e.val[0]));
        else          check("data_out", 32'(sfr.data_out), 32'(e.val));
      end
    end
  end

  initial begin
    idle();
    #3;
    check("rst_data_out",   32'(sfr.data_out),   32'h00);
    check("rst_bit_out",    32'(sfr.bit_out),    32'd0);
    check("rst_read_valid", 32'(sfr.read_valid), 32'd0);
    check("rst_pin_change", 32'(pin_change),     32'h00);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Idle pins read back the reset level.
    issue_read(8'h80, 1'b0, 1'b0, 1'b1, 8'hFF);
    idle();
    check("flags_idle", 32'(pin_change), 32'h00);

    // Pin change, flags, and clear on plain byte read.
    pins_in = 8'h5A;
    repeat (SETTLE) @(negedge clock);
    check("flags_5a", 32'(pin_change), 32'hA5);
    issue_read(8'h80, 1'b0, 1'b0, 1'b1, 8'h5A);
    idle();
    check("flags_clr", 32'(pin_change), 32'h00);

    // rmw reads the latch and keeps flags; plain read gets pins.
    latch_in = 8'h3C;
    pins_in  = 8'hC3;
    repeat (SETTLE) @(negedge clock);
    check("flags_c3", 32'(pin_change), 32'h99);
    issue_read(8'h80, 1'b0, 1'b1, 1'b1, 8'h3C);
    idle();
    check("flags_rmw_keep", 32'(pin_change), 32'h99);
    issue_read(8'h80, 1'b0, 1'b0, 1'b1, 8'hC3);
    idle();
    check("flags_clr2", 32'(pin_change), 32'h00);

    // Back-to-back bit reads, then non-hits.
    pins_in = 8'h08;
    repeat (SETTLE) @(negedge clock);
    issue_read(8'h83, 1'b1, 1'b0, 1'b1, 8'h01);
    check("b2b_valid1", 32'(sfr.read_valid), 32'd1);
    issue_read(8'h84, 1'b1, 1'b0, 1'b1, 8'h00);
    check("b2b_valid2", 32'(sfr.read_valid), 32'd1);
    issue_read(8'h90, 1'b0, 1'b0, 1'b0, 8'h00);
    check("nohit_90", 32'(sfr.read_valid), 32'd0);
    issue_read(8'h88, 1'b1, 1'b0, 1'b0, 8'h00);
    check("nohit_88", 32'(sfr.read_valid), 32'd0);
    issue_read(8'h83, 1'b0, 1'b0, 1'b0, 8'h00);
    check("nohit_byte83", 32'(sfr.read_valid), 32'd0);
    idle();
    check("hold_data", 32'(sfr.data_out), 32'hC3);
    check("hold_bit",  32'(sfr.bit_out),  32'd0);
    check("flags_bitread_keep", 32'(pin_change), 32'hCB);

    // Edge on pin 0 coincides with the clearing read: set wins.
    pins_in = 8'h09;
    repeat (LAT) @(negedge clock);
    issue_read(8'h80, 1'b0, 1'b0, 1'b1, 8'h09);
    idle();
    check("set_wins", 32'(pin_change), 32'h01);
    repeat (4) @(negedge clock);

`ifdef PORT_DEGLITCH_EN
    issue_read(8'h80, 1'b0, 1'b0, 1'b1, 8'h09);
    idle();
    pins_in = 8'h0D;
    repeat (3) @(negedge clock);
    pins_in = 8'h09;
    repeat (SETTLE + 4) @(negedge clock);
    check("dg_short_flag", 32'(pin_change), 32'h00);
    pins_in = 8'h0D;
    repeat (6) @(negedge clock);
    pins_in = 8'h09;
    issue_read(8'h80, 1'b0, 1'b0, 1'b1, 8'h0D);
    idle();
    repeat (SETTLE + 4) @(negedge clock);
    check("dg_long_flag", 32'(pin_change), 32'h04);
`endif

    // Asynchronous reset drops an active response immediately.
    issue_read(8'h80, 1'b0, 1'b0, 1'b1, 8'h09);
    check("pre_rst_valid", 32'(sfr.read_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_valid", 32'(sfr.read_valid), 32'd0);
    idle();
    repeat (2) @(negedge clock);
    check("rst_mid_data", 32'(sfr.data_out), 32'h00);
    check("rst_mid_flags", 32'(pin_change), 32'h00);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule
`default_nettype wire
